fft_frame_packer: RTL and testbench

Upstream framing stage for the streaming FFT core. Accepts an unframed stream of 14-bit complex samples, buffers them in a small FIFO, and presents them on the FFT core's Avalon-ST sink as packets of exactly N points. Each packet carries `sop` and `eop` markers, with the transform size and direction held stable for the whole packet. It absorbs FFT-side backpressure and returns it to the sample source.

---
 rtl/fft_frame_packer.sv | 202 ++++++++++++++++++++
 tb/tb_fft_frame_packer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_packer.sv
// fft_frame_packer: buffers an unframed stream of 14-bit complex samples in a
// small FIFO and presents it to the streaming FFT sink as packets of exactly
// N points, with sop/eop markers and per-packet size/direction held stable.
module fft_frame_packer #(
    parameter int          DEPTH   = 16,
    parameter logic [10:0] DEF_PTS = 11'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [13:0] in_real,
    input  logic [13:0] in_imag,
    input  logic [10:0] cfg_pts,
    input  logic        cfg_inverse,
    output logic        sink_valid,
    input  logic        sink_ready,
    output logic        sink_sop,
    output logic        sink_eop,
    output logic [13:0] sink_real,
    output logic [13:0] sink_imag,
    output logic [1:0]  sink_error,
    output logic [10:0] fftpts_in,
    output logic        inverse,
    output logic        cfg_err,
    output logic [15:0] frame_cnt
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(DEPTH);
    localparam int             NUM_SIZES  = 5;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    logic [27:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          rd_en;
    logic [27:0]   head;

    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);

    // Ready comes only from registered occupancy; held low while in reset.
    assign in_ready   = !full && !reset;
    assign sink_valid = !empty;

    // A flush discards whatever transfer happens in the same cycle.
    assign wr_en = in_valid && in_ready && !flush;
    assign rd_en = sink_valid && sink_ready && !flush;

    assign head      = mem[rd_ptr_reg];
    assign sink_real = sink_valid ? head[27:14] : '0;
    assign sink_imag = sink_valid ? head[13:0]  : '0;
    assign sink_error = 2'b00;

    // Storage array: written on an accepted sample, read asynchronously at the head.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= {in_real, in_imag};
        end
    end

    // Pointers and occupancy; reset and flush both empty the FIFO.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Configuration validation
    // ------------------------------------------------------------------
    logic [NUM_SIZES-1:0] size_hit;
    logic                 cfg_legal;
    logic [10:0]          cfg_sel_reg;
    logic                 cfg_err_reg;

    // Legal transform sizes are the powers of two from 64 up to 1024.
    generate
        for (genvar gi = 0; gi < NUM_SIZES; gi++) begin : g_size_match
            assign size_hit[gi] = (cfg_pts == (11'd64 << gi));
        end
    endgenerate

    assign cfg_legal = |size_hit;
    assign cfg_err   = cfg_err_reg;

    // Track the last legal size; any illegal request sets the sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_sel_reg <= DEF_PTS;
            cfg_err_reg <= 1'b0;
        end else if (cfg_legal) begin
            cfg_sel_reg <= cfg_pts;
        end else begin
            cfg_err_reg <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_t      state_reg, state_next;
    logic [10:0] pos_reg, pos_next;
    logic [10:0] frame_pts_reg, frame_pts_next;
    logic        frame_inv_reg, frame_inv_next;
    logic [15:0] frame_cnt_reg, frame_cnt_next;
    logic        last_beat;

    assign last_beat = (pos_reg == (frame_pts_reg - 11'd1));
    assign frame_cnt = frame_cnt_reg;

    // Frame state registers; the completed-packet counter survives a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            pos_reg       <= '0;
            frame_pts_reg <= DEF_PTS;
            frame_inv_reg <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            pos_reg       <= pos_next;
            frame_pts_reg <= frame_pts_next;
            frame_inv_reg <= frame_inv_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    // Next-state logic: the first read of a packet freezes its size and direction.
    always_comb begin
        state_next     = state_reg;
        pos_next       = pos_reg;
        frame_pts_next = frame_pts_reg;
        frame_inv_next = frame_inv_reg;
        frame_cnt_next = frame_cnt_reg;
        if (flush) begin
            state_next = ST_IDLE;
            pos_next   = '0;
        end else if (rd_en) begin
            case (state_reg)
                ST_IDLE: begin
                    frame_pts_next = cfg_sel_reg;
                    frame_inv_next = cfg_inverse;
                    pos_next       = 11'd1;
                    state_next     = ST_IN_FRAME;
                end
                default: begin
                    if (last_beat) begin
                        pos_next       = '0;
                        frame_cnt_next = frame_cnt_reg + 16'd1;
                        state_next     = ST_IDLE;
                    end else begin
                        pos_next = pos_reg + 11'd1;
                    end
                end
            endcase
        end
    end

    // Packet markers and FFT control: live config while idle, frozen within a packet.
    always_comb begin
        sink_sop  = 1'b0;
        sink_eop  = 1'b0;
        fftpts_in = cfg_sel_reg;
        inverse   = cfg_inverse;
        if (state_reg == ST_IDLE) begin
            sink_sop = sink_valid;
        end else begin
            fftpts_in = frame_pts_reg;
            inverse   = frame_inv_reg;
            sink_eop  = sink_valid && last_beat;
        end
    end

endmodule

// File: tb/tb_fft_frame_packer.sv
// Directed testbench for fft_frame_packer: reset state, basic framing,
// backpressure, mid-frame config change, illegal config, flush, back-to-back
// packets and frame counter wrap. Every expected value is hand-derived.
module tb_fft_frame_packer;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] in_real;
    logic [13:0] in_imag;
    logic [10:0] cfg_pts;
    logic        cfg_inverse;
    logic        sink_valid;
    logic        sink_ready;
    logic        sink_sop;
    logic        sink_eop;
    logic [13:0] sink_real;
    logic [13:0] sink_imag;
    logic [1:0]  sink_error;
    logic [10:0] fftpts_in;
    logic        inverse;
    logic        cfg_err;
    logic [15:0] frame_cnt;

    int n_asserts = 0;
    int n_fail    = 0;

    fft_frame_packer #(
        .DEPTH   (16),
        .DEF_PTS (11'd1024)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_real     (in_real),
        .in_imag     (in_imag),
        .cfg_pts     (cfg_pts),
        .cfg_inverse (cfg_inverse),
        .sink_valid  (sink_valid),
        .sink_ready  (sink_ready),
        .sink_sop    (sink_sop),
        .sink_eop    (sink_eop),
        .sink_real   (sink_real),
        .sink_imag   (sink_imag),
        .sink_error  (sink_error),
        .fftpts_in   (fftpts_in),
        .inverse     (inverse),
        .cfg_err     (cfg_err),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_real     = '0;
        in_imag     = '0;
        cfg_pts     = 11'd1024;
        cfg_inverse = 1'b0;
        sink_ready  = 1'b0;

        // ---------------- Reset state ----------------
        cycle();
        chk("rst_in_ready_low", 32'(in_ready), 0);
        cycle();
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_sink_valid", 32'(sink_valid), 0);
        chk("rst_sop", 32'(sink_sop), 0);
        chk("rst_eop", 32'(sink_eop), 0);
        chk("rst_real", 32'(sink_real), 0);
        chk("rst_imag", 32'(sink_imag), 0);
        chk("rst_error", 32'(sink_error), 0);
        chk("rst_fftpts", 32'(fftpts_in), 1024);
        chk("rst_inverse", 32'(inverse), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        $display("step reset: done");

        // ---------------- Basic 64-point frame ----------------
        cfg_pts = 11'd64;
        cycle();
        chk("basic_cfg_sel", 32'(fftpts_in), 64);
        sink_ready = 1'b1;
        in_valid   = 1'b1;
        in_real    = 14'd0;
        in_imag    = 14'd1000;
        #1;
        chk("basic_no_comb_path", 32'(sink_valid), 0);
        for (int i = 0; i < 64; i++) begin
            in_real = 14'(i);
            in_imag = 14'(i + 1000);
            cycle();
            chk("basic_valid", 32'(sink_valid), 1);
            chk("basic_real", 32'(sink_real), 32'(i));
            chk("basic_imag", 32'(sink_imag), 32'(i + 1000));
            chk("basic_sop", 32'(sink_sop), (i == 0) ? 1 : 0);
            chk("basic_eop", 32'(sink_eop), (i == 63) ? 1 : 0);
            chk("basic_fftpts", 32'(fftpts_in), 64);
        end
        in_valid = 1'b0;
        cycle();
        chk("basic_frame_cnt", 32'(frame_cnt), 1);
        chk("basic_drained", 32'(sink_valid), 0);
        $display("step basic frame: frame_cnt=%0d", frame_cnt);

        // ---------------- Backpressure ----------------
        sink_ready = 1'b0;
        in_valid   = 1'b1;
        in_imag    = '0;
        for (int i = 0; i < 16; i++) begin
            chk("bp_accept", 32'(in_ready), 1);
            in_real = 14'(100 + i);
            cycle();
        end
        chk("bp_full", 32'(in_ready), 0);
        in_real = 14'd999;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("bp_hold_valid", 32'(sink_valid), 1);
            chk("bp_hold_real", 32'(sink_real), 100);
            chk("bp_hold_sop", 32'(sink_sop), 1);
            chk("bp_hold_fftpts", 32'(fftpts_in), 64);
            chk("bp_hold_ready", 32'(in_ready), 0);
        end
        in_valid   = 1'b0;
        sink_ready = 1'b1;
        #1;
        chk("bp_ready_registered", 32'(in_ready), 0);
        for (int i = 0; i < 16; i++) begin
            chk("bp_drain_real", 32'(sink_real), 32'(100 + i));
            chk("bp_drain_sop", 32'(sink_sop), (i == 0) ? 1 : 0);
            cycle();
        end
        chk("bp_drained", 32'(sink_valid), 0);
        $display("step backpressure: 16 samples drained");

        // ---------------- Flush at beat 30 ----------------
        in_valid = 1'b1;
        for (int j = 0; j < 14; j++) begin
            in_real = 14'(200 + j);
            cycle();
            chk("fl_stream_real", 32'(sink_real), 32'(200 + j));
            chk("fl_stream_eop", 32'(sink_eop), 0);
        end
        in_real = 14'd300;
        cycle();
        chk("fl_beat30_real", 32'(sink_real), 300);
        flush   = 1'b1;
        in_real = 14'd301;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_empty", 32'(sink_valid), 0);
        chk("fl_eop", 32'(sink_eop), 0);
        chk("fl_frame_cnt", 32'(frame_cnt), 1);
        in_valid = 1'b1;
        in_real  = 14'd7;
        cycle();
        in_valid = 1'b0;
        chk("fl_next_valid", 32'(sink_valid), 1);
        chk("fl_next_sop", 32'(sink_sop), 1);
        chk("fl_next_real", 32'(sink_real), 7);
        chk("fl_next_eop", 32'(sink_eop), 0);
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("fl2_empty", 32'(sink_valid), 0);
        chk("fl2_frame_cnt", 32'(frame_cnt), 1);
        $display("step flush: frame_cnt=%0d", frame_cnt);

        // ---------------- Config change mid-frame ----------------
        cfg_pts = 11'd256;
        cycle();
        chk("cc_cfg_sel", 32'(fftpts_in), 256);
        in_valid = 1'b1;
        for (int i = 0; i < 384; i++) begin
            int p;
            int ln;
            p  = (i < 256) ? i : i - 256;
            ln = (i < 256) ? 256 : 128;
            in_real = 14'(i);
            cycle();
            chk("cc_real", 32'(sink_real), 32'(i));
            chk("cc_sop", 32'(sink_sop), (p == 0) ? 1 : 0);
            chk("cc_eop", 32'(sink_eop), (p == ln - 1) ? 1 : 0);
            chk("cc_fftpts", 32'(fftpts_in), 32'(ln));
            chk("cc_inverse", 32'(inverse), (i < 256) ? 0 : 1);
            if (i == 10) begin
                cfg_pts     = 11'd128;
                cfg_inverse = 1'b1;
            end
        end
        in_valid = 1'b0;
        cycle();
        chk("cc_frame_cnt", 32'(frame_cnt), 3);
        cfg_inverse = 1'b0;
        $display("step config change: frame_cnt=%0d", frame_cnt);

        // ---------------- Illegal config ----------------
        cfg_pts = 11'd512;
        cycle();
        chk("ic_cfg_sel", 32'(fftpts_in), 512);
        chk("ic_err_before", 32'(cfg_err), 0);
        cfg_pts = 11'd100;
        #1;
        chk("ic_err_registered", 32'(cfg_err), 0);
        cycle();
        chk("ic_err_rise", 32'(cfg_err), 1);
        chk("ic_keep_sel", 32'(fftpts_in), 512);
        in_valid = 1'b1;
        for (int i = 0; i < 512; i++) begin
            in_real = 14'(i);
            cycle();
            chk("ic_sop", 32'(sink_sop), (i == 0) ? 1 : 0);
            chk("ic_eop", 32'(sink_eop), (i == 511) ? 1 : 0);
            chk("ic_fftpts", 32'(fftpts_in), 512);
        end
        in_valid = 1'b0;
        cycle();
        chk("ic_frame_cnt", 32'(frame_cnt), 4);
        chk("ic_err_sticky", 32'(cfg_err), 1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("ic_err_after_flush", 32'(cfg_err), 1);
        chk("ic_sel_after_flush", 32'(fftpts_in), 512);
        $display("step illegal config: cfg_err=%0d", cfg_err);

        // ---------------- Back-to-back 64-point frames ----------------
        cfg_pts = 11'd64;
        cycle();
        in_valid = 1'b1;
        for (int i = 0; i < 192; i++) begin
            in_real = 14'(i);
            cycle();
            chk("bb_valid", 32'(sink_valid), 1);
            chk("bb_sop", 32'(sink_sop), ((i % 64) == 0) ? 1 : 0);
            chk("bb_eop", 32'(sink_eop), ((i % 64) == 63) ? 1 : 0);
        end
        in_valid = 1'b0;
        cycle();
        chk("bb_frame_cnt", 32'(frame_cnt), 7);
        $display("step back-to-back: frame_cnt=%0d", frame_cnt);

        // ---------------- Frame counter wrap ----------------
        force dut.frame_cnt_reg = 16'hFFFF;
        #1;
        release dut.frame_cnt_reg;
        #1;
        chk("wr_preset", 32'(frame_cnt), 65535);
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_real = 14'(i);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("wr_wrap", 32'(frame_cnt), 0);
        $display("step wrap: frame_cnt=%0d", frame_cnt);

        // ---------------- Reset clears sticky error ----------------
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        chk("rst2_cfg_err", 32'(cfg_err), 0);
        chk("rst2_fftpts", 32'(fftpts_in), 1024);
        $display("step final reset: cfg_err=%0d", cfg_err);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
